// File: rtl/nebula_local_inject_arbiter.sv
// Packet-atomic round-robin arbiter for a router local injection port.
// Define NEBULA_INJ_QOS_EN to give above-normal-QoS requesters precedence in IDLE.
package nebula_inj_pkg;
  localparam int PERF_COUNTER_WIDTH = 32;
  localparam logic [1:0] QOS_NORMAL = 2'd1;
  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'd0,
    FLIT_BODY   = 2'd1,
    FLIT_TAIL   = 2'd2,
    FLIT_SINGLE = 2'd3
  } flit_type_e;
  typedef struct packed {
    flit_type_e  ftype;
    logic [1:0]  qos;
    logic [15:0] seq;
    logic [31:0] data;
  } noc_flit_t;
endpackage

module nebula_local_inject_arbiter
  import nebula_inj_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  noc_flit_t [NUM_REQ-1:0]       req_flit,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output noc_flit_t                     out_flit,
  input  logic                          out_ready,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          locked,
  output logic [PERF_COUNTER_WIDTH-1:0] packets_granted,
  output logic                          lock_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

  // Returns {found, index} of the first set bit at or after ptr, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] mask, input logic [IW-1:0] ptr);
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (mask[idx]) res = {1'b1, IW'(idx)};
      else           res = res;
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    else                        return p + 1'b1;
  endfunction

  state_e                        state_r;
  logic [IW-1:0]                 rr_ptr_r;
  logic [IW-1:0]                 owner_r;
  logic                          locked_r;
  logic                          out_valid_r;
  noc_flit_t                     out_flit_r;
  logic [PERF_COUNTER_WIDTH-1:0] pkt_cnt_r;
  logic [TW-1:0]                 to_cnt_r;
  logic                          lock_timeout_r;

  logic                          slot_free_s;
  logic [IW:0]                   pick_s;
  logic [IW-1:0]                 sel_s;
  logic                          grant_s;
  logic                          accept_s;
  noc_flit_t                     acc_flit_s;
`ifdef NEBULA_INJ_QOS_EN
  logic [NUM_REQ-1:0]            hi_mask_s;
`endif

  // Winner selection, ready generation and handshake detection
  always_comb begin
    slot_free_s = !out_valid_r || out_ready;
`ifdef NEBULA_INJ_QOS_EN
    hi_mask_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (req_flit[i].qos > QOS_NORMAL)) hi_mask_s[i] = 1'b1;
      else                                                  hi_mask_s[i] = 1'b0;
    end
    pick_s = (|hi_mask_s) ? rr_pick(hi_mask_s, rr_ptr_r) : rr_pick(req_valid, rr_ptr_r);
`else
    pick_s = rr_pick(req_valid, rr_ptr_r);
`endif
    sel_s   = '0;
    grant_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sel_s   = pick_s[IW-1:0];
        grant_s = pick_s[IW];
      end
      ST_LOCKED: begin
        sel_s   = owner_r;
        grant_s = 1'b1;
      end
      default: begin
        sel_s   = '0;
        grant_s = 1'b0;
      end
    endcase
    req_ready = '0;
    if (rst_n && grant_s && slot_free_s) req_ready[sel_s] = 1'b1;
    else                                 req_ready = '0;
    accept_s   = req_valid[sel_s] && req_ready[sel_s];
    acc_flit_s = req_flit[sel_s];
  end

  // Arbitration state, output register, packet counter and lock watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      rr_ptr_r       <= '0;
      owner_r        <= '0;
      locked_r       <= 1'b0;
      out_valid_r    <= 1'b0;
      out_flit_r     <= '0;
      pkt_cnt_r      <= '0;
      to_cnt_r       <= '0;
      lock_timeout_r <= 1'b0;
    end else begin
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_flit_r  <= acc_flit_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      case (state_r)
        ST_IDLE: begin
          to_cnt_r <= '0;
          if (accept_s) begin
            owner_r <= sel_s;
            // Stray BODY/TAIL in IDLE is forwarded like a SINGLE but not counted
            case (acc_flit_s.ftype)
              FLIT_HEAD: begin
                state_r   <= ST_LOCKED;
                locked_r  <= 1'b1;
                pkt_cnt_r <= pkt_cnt_r + 1'b1;
              end
              FLIT_SINGLE: begin
                rr_ptr_r  <= next_ptr(sel_s);
                pkt_cnt_r <= pkt_cnt_r + 1'b1;
              end
              default: rr_ptr_r <= next_ptr(sel_s);
            endcase
          end
        end
        ST_LOCKED: begin
          if (accept_s) begin
            to_cnt_r <= '0;
            if (acc_flit_s.ftype == FLIT_TAIL) begin
              state_r  <= ST_IDLE;
              locked_r <= 1'b0;
              rr_ptr_r <= next_ptr(owner_r);
            end
          end else if (!req_valid[owner_r]) begin
            if (to_cnt_r != TW'(LOCK_TIMEOUT)) to_cnt_r <= to_cnt_r + 1'b1;
            if (to_cnt_r == TW'(LOCK_TIMEOUT - 1)) lock_timeout_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          locked_r <= 1'b0;
          to_cnt_r <= '0;
        end
      endcase
    end
  end

  assign out_valid       = out_valid_r;
  assign out_flit        = out_flit_r;
  assign owner           = owner_r;
  assign locked          = locked_r;
  assign packets_granted = pkt_cnt_r;
  assign lock_timeout    = lock_timeout_r;

endmodule
